// File: rtl/mmu_sdspi_pkg.sv
// Shared definitions for the MMU SD-card SPI master: register map, STAT bit
// positions and the transfer FSM encoding.
package mmu_sdspi_pkg;

  localparam logic [1:0] SD_REG_DATA = 2'd0;
  localparam logic [1:0] SD_REG_STAT = 2'd1;
  localparam logic [1:0] SD_REG_DIV  = 2'd2;
  localparam logic [1:0] SD_REG_RSVD = 2'd3;

  localparam int STAT_BUSY = 7;
  localparam int STAT_OVR  = 6;
  localparam int STAT_AUTO = 1;
  localparam int STAT_CS   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sd_state_e;

endpackage

// File: rtl/mmu_sdspi_clkdiv.sv
// SCLK divider: counts E falls down from DIV while shifting and strobes
// tick_o on the fall where SCLK must toggle.
module mmu_sdspi_clkdiv (
  input  logic       E,
  input  logic       RESET,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [7:0] div_i,
  output logic       tick_o
);

  logic [7:0] divcnt_q;
  logic [7:0] divcnt_d;

  assign tick_o = run_i && (divcnt_q == 8'd0);

  // DIV is read live at every reload, so a mid-transfer DIV write lands here.
  always_comb begin
    divcnt_d = divcnt_q;
    if (load_i) begin
      divcnt_d = div_i;
    end else if (run_i) begin
      if (divcnt_q == 8'd0) divcnt_d = div_i;
      else                  divcnt_d = divcnt_q - 8'd1;
    end
  end

  always_ff @(negedge E or posedge RESET) begin
    if (RESET) divcnt_q <= 8'd0;
    else       divcnt_q <= divcnt_d;
  end

endmodule

// File: rtl/mmu_sdspi.sv
// SD card SPI master (mode 0, MSB first) on the MMU I/O window; all state
// advances on the falling edge of the 6809 E clock.
module mmu_sdspi #(
  parameter logic [7:0] DIV_DEFAULT = 8'd0,
  parameter logic       IDLE_MOSI   = 1'b1
) (
  input  logic       E,
  input  logic       RESET,
  input  logic       SEL,
  input  logic       RnW,
  input  logic [1:0] ADDR,
  input  logic [7:0] DATA_in,
  output logic [7:0] DATA_out,
  output logic       DATA_oe,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SD_nCS,
  output logic       BUSY
);
  import mmu_sdspi_pkg::*;

  sd_state_e  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic       samp_q, samp_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
  logic       auto_q, auto_d;
  logic       cs_q, cs_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] div_q, div_d;

  logic       wr, rd, data_hit, wr_data, start_req, idle, start, tick;
  logic [7:0] tx;
  logic [7:0] rd_mux;

  assign wr        = SEL && !RnW;
  assign rd        = SEL && RnW;
  assign data_hit  = (ADDR == SD_REG_DATA);
  assign wr_data   = wr && data_hit;
  // An AUTO read of DATA clocks out 0xFF and fetches the next card byte.
  assign start_req = wr_data || (rd && data_hit && auto_q);
  assign idle      = (state_q == ST_IDLE);
  assign start     = start_req && idle;
  assign tx        = wr_data ? DATA_in : 8'hFF;

  mmu_sdspi_clkdiv u_clkdiv (
    .E      (E),
    .RESET  (RESET),
    .load_i (start),
    .run_i  (state_q == ST_SHIFT),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    samp_d   = samp_q;
    bitcnt_d = bitcnt_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;
    auto_d   = auto_q;
    cs_d     = cs_q;
    rx_d     = rx_q;
    div_d    = div_q;

    if (wr && ADDR == SD_REG_STAT) begin
      auto_d = DATA_in[STAT_AUTO];
      cs_d   = DATA_in[STAT_CS];
    end
    if (wr && ADDR == SD_REG_DIV) div_d = DATA_in;
    if (rd && ADDR == SD_REG_STAT) ovr_d = 1'b0;
    if (start_req && !idle) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d  = tx;
          mosi_d   = tx[7];
          bitcnt_d = 3'd0;
          busy_d   = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            samp_d = MISO;
          end else begin
            shreg_d  = {shreg_q[6:0], samp_q};
            mosi_d   = shreg_q[6];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rx_d    = shreg_q;
        busy_d  = 1'b0;
        mosi_d  = IDLE_MOSI;
        sclk_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge E or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      shreg_q  <= 8'h00;
      samp_q   <= 1'b0;
      bitcnt_q <= 3'd0;
      sclk_q   <= 1'b0;
      mosi_q   <= IDLE_MOSI;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      auto_q   <= 1'b0;
      cs_q     <= 1'b0;
      rx_q     <= 8'hFF;
      div_q    <= DIV_DEFAULT;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      samp_q   <= samp_d;
      bitcnt_q <= bitcnt_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      auto_q   <= auto_d;
      cs_q     <= cs_d;
      rx_q     <= rx_d;
      div_q    <= div_d;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (ADDR)
      SD_REG_DATA: rd_mux = rx_q;
      SD_REG_STAT: rd_mux = {busy_q, ovr_q, 4'b0000, auto_q, cs_q};
      SD_REG_DIV:  rd_mux = div_q;
      default:     rd_mux = 8'h00;
    endcase
  end

  assign DATA_out = rd ? rd_mux : 8'h00;
  assign DATA_oe  = rd;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign SD_nCS   = !cs_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mmu_sdspi.sv
// Bench for mmu_sdspi: byte-level reference model, table plus random
// transfers, and hand-written corner sequences.
module tb_mmu_sdspi;

  logic       E = 1'b0;
  logic       RESET = 1'b1;
  logic       SEL = 1'b0;
  logic       RnW = 1'b1;
  logic [1:0] ADDR = 2'd0;
  logic [7:0] DATA_in = 8'h00;
  logic [7:0] DATA_out;
  logic       DATA_oe;
  logic       SCLK, MOSI, SD_nCS, BUSY;
  logic       MISO = 1'b1;

  mmu_sdspi dut (
    .E(E), .RESET(RESET), .SEL(SEL), .RnW(RnW), .ADDR(ADDR),
    .DATA_in(DATA_in), .DATA_out(DATA_out), .DATA_oe(DATA_oe),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SD_nCS(SD_nCS), .BUSY(BUSY)
  );

  always #10 E = ~E;

  int n_chk = 0;
  int n_pass = 0;

  // monitor / card model state
  logic [7:0] miso_byte = 8'hFF;
  logic [7:0] mosi_cap;
  logic [7:0] rd_val;
  logic       oe_val;
  logic       sclk_prev = 1'b0;
  int         n_sfall, n_rise, t_rise0, t_fall0;
  int         fall_cnt = 0;
  int         start_cnt;

  // reference model
  logic [7:0] m_rx = 8'hFF;
  logic [7:0] old_rx;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
    logic [7:0] div;
    logic       auto_m;
    logic       cs;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One E cycle: drive bus and MISO in the high phase, sample after the fall.
  task automatic step(input logic sel, input logic rnw, input logic [1:0] addr, input logic [7:0] din);
    @(posedge E);
    SEL = sel; RnW = rnw; ADDR = addr; DATA_in = din;
    MISO = (n_sfall < 8) ? miso_byte[7 - n_sfall] : 1'b1;
    #5;
    rd_val = DATA_out;
    oe_val = DATA_oe;
    @(negedge E);
    #1;
    fall_cnt++;
    if (SCLK && !sclk_prev) begin
      n_rise++;
      mosi_cap = {mosi_cap[6:0], MOSI};
      if (t_rise0 < 0) t_rise0 = fall_cnt;
    end
    if (!SCLK && sclk_prev) begin
      n_sfall++;
      if (t_fall0 < 0) t_fall0 = fall_cnt;
    end
    sclk_prev = SCLK;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b1, 2'd0, 8'h00);
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic auto_m);
    n_sfall = 0; n_rise = 0; mosi_cap = 8'h00; t_rise0 = -1; t_fall0 = -1;
    old_rx = m_rx;
    if (auto_m) begin
      step(1'b1, 1'b1, 2'd0, 8'h00);
      check("auto_read_old_rx", rd_val, old_rx);
    end else begin
      step(1'b1, 1'b0, 2'd0, tx);
    end
    start_cnt = fall_cnt;
  endtask

  task automatic finish_xfer(input logic [7:0] exp_mosi, input int exp_lat, input int div, input logic do_rd);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step(do_rd, 1'b1, 2'd0, 8'h00);
      if (!BUSY) done = 1;
    end
    check("busy_timeout", done, 1);
    check("latency", fall_cnt - start_cnt + 1, exp_lat);
    if (do_rd) check("done_cycle_old_rx", rd_val, old_rx);
    check("mosi_bits", mosi_cap, exp_mosi);
    check("sclk_rises", n_rise, 8);
    check("sclk_high_time", t_fall0 - t_rise0, div + 1);
    check("idle_sclk_mosi", {SCLK, MOSI}, 2'b01);
    m_rx = miso_byte;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge E);
    #1;
    check("rst_outputs", {SCLK, MOSI, SD_nCS, BUSY, DATA_oe}, 5'b01100);
    check("rst_data_out", DATA_out, 8'h00);
    RESET = 1'b0;
    step(1'b1, 1'b1, 2'd0, 8'h00); check("rst_rx", rd_val, 8'hFF);
    step(1'b1, 1'b1, 2'd1, 8'h00); check("rst_stat", rd_val, 8'h00);
    step(1'b1, 1'b1, 2'd2, 8'h00); check("rst_div", rd_val, 8'h00);

    // table: fixed corner vectors, then random ones from the model
    vecs[0] = '{tx: 8'hA5, miso: 8'h3C, div: 8'd0, auto_m: 1'b0, cs: 1'b1, exp_rx: 8'h3C, exp_lat: 18};
    vecs[1] = '{tx: 8'h5A, miso: 8'hC3, div: 8'd3, auto_m: 1'b0, cs: 1'b1, exp_rx: 8'hC3, exp_lat: 66};
    vecs[2] = '{tx: 8'h00, miso: 8'hFF, div: 8'd1, auto_m: 1'b0, cs: 1'b0, exp_rx: 8'hFF, exp_lat: 34};
    vecs[3] = '{tx: 8'h00, miso: 8'h96, div: 8'd2, auto_m: 1'b1, cs: 1'b1, exp_rx: 8'h96, exp_lat: 50};
    for (int v = 4; v < 10; v++) begin
      vecs[v].tx     = 8'($urandom);
      vecs[v].miso   = 8'($urandom);
      vecs[v].div    = 8'($urandom_range(0, 3));
      vecs[v].auto_m = 1'($urandom_range(0, 1));
      vecs[v].cs     = 1'($urandom_range(0, 1));
      vecs[v].exp_rx = vecs[v].miso;
      vecs[v].exp_lat = 16 * (int'(vecs[v].div) + 1) + 2;
    end

    for (int v = 0; v < 10; v++) begin
      step(1'b1, 1'b0, 2'd2, vecs[v].div);
      step(1'b1, 1'b1, 2'd2, 8'h00); check("div_readback", rd_val, vecs[v].div);
      step(1'b1, 1'b0, 2'd1, {6'b0, vecs[v].auto_m, vecs[v].cs});
      check("cs_pin", SD_nCS, !vecs[v].cs);
      miso_byte = vecs[v].miso;
      start_xfer(vecs[v].tx, vecs[v].auto_m);
      finish_xfer(vecs[v].auto_m ? 8'hFF : vecs[v].tx, vecs[v].exp_lat, int'(vecs[v].div), !vecs[v].auto_m);
      step(1'b1, 1'b0, 2'd1, {7'b0, vecs[v].cs});
      step(1'b1, 1'b1, 2'd0, 8'h00); check("rx_read", rd_val, vecs[v].exp_rx);
    end

    // back-to-back DATA writes: second ignored, OVR sticky until STAT read
    step(1'b1, 1'b0, 2'd2, 8'd0);
    step(1'b1, 1'b0, 2'd1, 8'h01);
    miso_byte = 8'h5E;
    start_xfer(8'h81, 1'b0);
    step(1'b1, 1'b0, 2'd0, 8'h7E);
    step(1'b1, 1'b1, 2'd1, 8'h00); check("stat_ovr", rd_val, 8'hC1);
    step(1'b1, 1'b1, 2'd1, 8'h00); check("stat_ovr_cleared", rd_val, 8'h81);
    finish_xfer(8'h81, 18, 0, 1'b1);

    // AUTO reads: stale RX returned, 0xFF shifted out, busy read flags OVR
    step(1'b1, 1'b0, 2'd1, 8'h03);
    miso_byte = 8'h00;
    start_xfer(8'h00, 1'b1);
    step(1'b1, 1'b1, 2'd0, 8'h00); check("busy_auto_stale", rd_val, old_rx);
    step(1'b1, 1'b1, 2'd1, 8'h00); check("stat_busy_auto", rd_val, 8'hC3);
    finish_xfer(8'hFF, 18, 0, 1'b0);
    miso_byte = 8'hE7;
    start_xfer(8'h00, 1'b1);
    finish_xfer(8'hFF, 18, 0, 1'b0);
    step(1'b1, 1'b0, 2'd1, 8'h00);
    step(1'b1, 1'b1, 2'd0, 8'h00); check("auto_rx", rd_val, 8'hE7);

    // CS pin and reserved register
    step(1'b1, 1'b0, 2'd1, 8'h01); check("ncs_low", SD_nCS, 1'b0);
    step(1'b1, 1'b0, 2'd1, 8'h00); check("ncs_high", SD_nCS, 1'b1);
    step(1'b1, 1'b0, 2'd3, 8'h55);
    step(1'b1, 1'b1, 2'd3, 8'h00); check("rsvd_read", {oe_val, rd_val}, 9'h100);

    // reset while SCLK is high mid-transfer
    step(1'b1, 1'b0, 2'd2, 8'd3);
    step(1'b1, 1'b0, 2'd1, 8'h01);
    miso_byte = 8'h12;
    start_xfer(8'h00, 1'b0);
    for (int i = 0; i < 40 && !(SCLK && n_rise >= 2); i++) idle_cycle();
    check("mid_shift_sclk", SCLK, 1'b1);
    #3 RESET = 1'b1;
    #1;
    check("abort_outputs", {SCLK, MOSI, SD_nCS, BUSY}, 4'b0110);
    #5 RESET = 1'b0;
    sclk_prev = 1'b0;
    step(1'b1, 1'b1, 2'd0, 8'h00); check("abort_rx", rd_val, 8'hFF);
    step(1'b1, 1'b1, 2'd1, 8'h00); check("abort_stat", rd_val, 8'h00);
    step(1'b1, 1'b1, 2'd2, 8'h00); check("abort_div", rd_val, 8'h00);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
